// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issue-side controller for the 4-bit combinational ALU.
// Snapshots operands at accept, lets the ALU settle for a cycle, then retires into regfile/flags.
module alu_op_sequencer #(
  parameter  int unsigned DATA_W = 4,
  parameter  int unsigned NREG   = 4,
  localparam int unsigned AW     = $clog2(NREG),
  localparam int unsigned OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   instr_op,
  input  logic              instr_ld,
  input  logic [AW-1:0]     instr_dst,
  input  logic [AW-1:0]     instr_sa,
  input  logic [AW-1:0]     instr_sb,
  input  logic              instr_imm_en,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [DATA_W-1:0] alu_A,
  output logic [DATA_W-1:0] alu_B,
  output logic [OP_W-1:0]   alu_G_select,
  input  logic [DATA_W-1:0] alu_G,
  input  logic              alu_C,
  input  logic              alu_V,
  output logic              flag_C,
  output logic              flag_V,
  output logic              flag_Z,
  output logic              flag_N,
  output logic              done,
  output logic [DATA_W-1:0] result,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRIVE   = 2'd1,
    S_CAPTURE = 2'd2
  } state_e;

  typedef struct packed {
    logic              ld;
    logic [AW-1:0]     dst;
    logic [DATA_W-1:0] imm;
  } pend_t;

  typedef struct packed {
    logic c;
    logic v;
    logic z;
    logic n;
  } flags_t;

  state_e            state_q, state_d;
  pend_t             pend_q, pend_d;
  flags_t            flags_q, flags_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_sel_q, alu_sel_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              done_q, done_d;
  logic              accept_c;

  assign accept_c = instr_valid && (state_q == S_IDLE);

  // Next-state and datapath updates; operands are snapshotted at accept so dst may alias a source.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    flags_d   = flags_q;
    regs_d    = regs_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    result_d  = result_q;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          state_d   = S_DRIVE;
          pend_d    = '{ld: instr_ld, dst: instr_dst, imm: instr_imm};
          alu_a_d   = regs_q[instr_sa];
          alu_b_d   = instr_imm_en ? instr_imm : regs_q[instr_sb];
          alu_sel_d = instr_op;
        end
      end
      S_DRIVE: state_d = S_CAPTURE;
      S_CAPTURE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (pend_q.ld) begin
          regs_d[pend_q.dst] = pend_q.imm;
          result_d           = pend_q.imm;
        end else begin
          regs_d[pend_q.dst] = alu_G;
          result_d           = alu_G;
          flags_d            = '{c: alu_C, v: alu_V, z: (alu_G == '0), n: alu_G[DATA_W-1]};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any in-flight instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pend_q    <= '0;
      flags_q   <= '0;
      regs_q    <= '{default: '0};
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      flags_q   <= flags_d;
      regs_q    <= regs_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      result_q  <= result_d;
      done_q    <= done_d;
    end
  end

  assign instr_ready  = (state_q == S_IDLE);
  assign alu_A        = alu_a_q;
  assign alu_B        = alu_b_q;
  assign alu_G_select = alu_sel_q;
  assign flag_C       = flags_q.c;
  assign flag_V       = flags_q.v;
  assign flag_Z       = flags_q.z;
  assign flag_N       = flags_q.n;
  assign done         = done_q;
  assign result       = result_q;
  assign dbg_data     = regs_q[dbg_addr];

endmodule
